// File: rtl/edge_bbox_tracker.sv
// Binarises Sobel edge magnitudes against a per-frame threshold and tracks the
// bounding box, centre and pixel count of edge pixels, published once per frame.
module edge_bbox_tracker #(
    parameter int H_SIZE     = 64,
    parameter int V_SIZE     = 64,
    parameter int MIN_PIXELS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [7:0]  threshold,
    input  logic [7:0]  in_sobel,
    input  logic        in_de,
    input  logic        in_hsync,
    input  logic        in_vsync,
    output logic [7:0]  out_bin,
    output logic        out_de,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic [9:0]  x_min,
    output logic [9:0]  x_max,
    output logic [9:0]  y_min,
    output logic [9:0]  y_max,
    output logic [9:0]  x_center,
    output logic [9:0]  y_center,
    output logic [19:0] pix_count,
    output logic        obj_found,
    output logic        frame_valid,
    output logic [1:0]  o_dbg_state
);

    localparam logic [9:0]  X_LAST  = 10'(H_SIZE - 1);
    localparam logic [9:0]  Y_LAST  = 10'(V_SIZE - 1);
    localparam logic [19:0] CNT_SAT = 20'hFFFFF;
    localparam logic [19:0] CNT_MIN = 20'(MIN_PIXELS);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ARM       = 2'd1,
        ACTIVE    = 2'd2,
        PUBLISH   = 2'd3
    } state_t;

    state_t      r_state, w_next_state;
    logic [7:0]  r_thr;
    logic [7:0]  r_bin;
    logic        r_de_d, r_hsync_d, r_vsync_d;
    logic [9:0]  r_x_cnt, r_y_cnt;
    logic [9:0]  r_acc_xmin, r_acc_xmax, r_acc_ymin, r_acc_ymax;
    logic [19:0] r_acc_cnt;
    logic [9:0]  r_x_min, r_x_max, r_y_min, r_y_max, r_x_center, r_y_center;
    logic [19:0] r_pix_count;
    logic        r_obj_found, r_frame_valid;

    logic        w_vs_rise, w_edge, w_arm, w_accum, w_publish;
    logic [10:0] w_xsum, w_ysum;

    assign w_vs_rise = in_vsync & ~r_vsync_d;
    assign w_edge    = in_de & (in_sobel >= r_thr);
    assign w_xsum    = {1'b0, r_acc_xmin} + {1'b0, r_acc_xmax};
    assign w_ysum    = {1'b0, r_acc_ymin} + {1'b0, r_acc_ymax};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_SYNC;
        end else if (ce) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_arm        = 1'b0;
        w_accum      = 1'b0;
        w_publish    = 1'b0;
        case (r_state)
            WAIT_SYNC: if (w_vs_rise) w_next_state = ARM;
            ARM: begin
                w_arm        = 1'b1;
                w_next_state = ACTIVE;
            end
            ACTIVE: begin
                w_accum = w_edge;
                if (w_vs_rise) w_next_state = PUBLISH;
            end
            PUBLISH: begin
                w_publish    = 1'b1;
                w_next_state = ARM;
            end
            default: w_next_state = WAIT_SYNC;
        endcase
    end

    // Video path; the delayed de/vsync also serve as the edge detectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin     <= 8'h00;
            r_de_d    <= 1'b0;
            r_hsync_d <= 1'b0;
            r_vsync_d <= 1'b0;
            r_thr     <= 8'hFF;
        end else if (ce) begin
            r_bin     <= w_edge ? 8'hFF : 8'h00;
            r_de_d    <= in_de;
            r_hsync_d <= in_hsync;
            r_vsync_d <= in_vsync;
            if (w_arm) r_thr <= threshold;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_cnt <= 10'd0;
            r_y_cnt <= 10'd0;
        end else if (ce) begin
            if (w_arm) begin
                r_x_cnt <= 10'd0;
                r_y_cnt <= 10'd0;
            end else begin
                if (in_de) begin
                    if (r_x_cnt != X_LAST) r_x_cnt <= r_x_cnt + 10'd1;
                end else begin
                    r_x_cnt <= 10'd0;
                end
                if (r_de_d && !in_de && r_y_cnt != Y_LAST) r_y_cnt <= r_y_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_xmin <= 10'd0;
            r_acc_xmax <= 10'd0;
            r_acc_ymin <= 10'd0;
            r_acc_ymax <= 10'd0;
            r_acc_cnt  <= 20'd0;
        end else if (ce) begin
            if (w_arm) begin
                r_acc_xmin <= 10'h3FF;
                r_acc_xmax <= 10'd0;
                r_acc_ymin <= 10'h3FF;
                r_acc_ymax <= 10'd0;
                r_acc_cnt  <= 20'd0;
            end else if (w_accum) begin
                if (r_x_cnt < r_acc_xmin) r_acc_xmin <= r_x_cnt;
                if (r_x_cnt > r_acc_xmax) r_acc_xmax <= r_x_cnt;
                if (r_y_cnt < r_acc_ymin) r_acc_ymin <= r_y_cnt;
                if (r_y_cnt > r_acc_ymax) r_acc_ymax <= r_y_cnt;
                if (r_acc_cnt != CNT_SAT) r_acc_cnt <= r_acc_cnt + 20'd1;
            end
        end
    end

    // An empty frame reports an all-zero box rather than the 3FF/0 sentinels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_min       <= 10'd0;
            r_x_max       <= 10'd0;
            r_y_min       <= 10'd0;
            r_y_max       <= 10'd0;
            r_x_center    <= 10'd0;
            r_y_center    <= 10'd0;
            r_pix_count   <= 20'd0;
            r_obj_found   <= 1'b0;
            r_frame_valid <= 1'b0;
        end else if (ce) begin
            r_frame_valid <= w_publish;
            if (w_publish) begin
                r_pix_count <= r_acc_cnt;
                r_obj_found <= (r_acc_cnt >= CNT_MIN);
                if (r_acc_cnt == 20'd0) begin
                    r_x_min    <= 10'd0;
                    r_x_max    <= 10'd0;
                    r_y_min    <= 10'd0;
                    r_y_max    <= 10'd0;
                    r_x_center <= 10'd0;
                    r_y_center <= 10'd0;
                end else begin
                    r_x_min    <= r_acc_xmin;
                    r_x_max    <= r_acc_xmax;
                    r_y_min    <= r_acc_ymin;
                    r_y_max    <= r_acc_ymax;
                    r_x_center <= w_xsum[10:1];
                    r_y_center <= w_ysum[10:1];
                end
            end
        end
    end

    assign out_bin     = r_bin;
    assign out_de      = r_de_d;
    assign out_hsync   = r_hsync_d;
    assign out_vsync   = r_vsync_d;
    assign x_min       = r_x_min;
    assign x_max       = r_x_max;
    assign y_min       = r_y_min;
    assign y_max       = r_y_max;
    assign x_center    = r_x_center;
    assign y_center    = r_y_center;
    assign pix_count   = r_pix_count;
    assign obj_found   = r_obj_found;
    assign frame_valid = r_frame_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_edge_bbox_tracker.sv
// Directed-frame bench for edge_bbox_tracker: a frame-level model predicts the
// video stream and per-frame results, checked every cycle, plus literal pins.
module tb_edge_bbox_tracker;

    localparam int K_PASS   = 0;
    localparam int K_RECT   = 1;
    localparam int K_EMPTY  = 2;
    localparam int K_FULL   = 3;
    localparam int K_CORNER = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce = 1'b0;
    logic [7:0]  threshold = 8'd0;
    logic [7:0]  in_sobel = 8'd0;
    logic        in_de = 1'b0;
    logic        in_hsync = 1'b0;
    logic        in_vsync = 1'b0;
    logic [7:0]  out_bin;
    logic        out_de, out_hsync, out_vsync;
    logic [9:0]  x_min, x_max, y_min, y_max, x_center, y_center;
    logic [19:0] pix_count;
    logic        obj_found, frame_valid;
    logic [1:0]  dbg_state;

    edge_bbox_tracker dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .threshold(threshold),
        .in_sobel(in_sobel), .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .out_bin(out_bin), .out_de(out_de), .out_hsync(out_hsync), .out_vsync(out_vsync),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .x_center(x_center), .y_center(y_center), .pix_count(pix_count),
        .obj_found(obj_found), .frame_valid(frame_valid), .o_dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [9:0]  xmn, xmx, ymn, ymx, xc, yc;
        logic [19:0] cnt;
        logic        obj;
    } res_t;

    // scoreboard
    int          n_checks = 0;
    int          n_errors = 0;
    int          fv_seen = 0;
    logic [10:0] exp_q[$];
    int          exp_due_q[$];
    res_t        res_q[$];
    int          res_due_q[$];
    logic [10:0] cur_vid = '0;
    res_t        cur_res = '0;

    // frame-level model
    logic [10:0] last_vid = '0;
    logic [7:0]  m_thr = 8'hFF;
    logic        m_prev_vs = 1'b0;
    logic        m_active = 1'b0;
    int          m_arm_wait = 0;
    int          a_xmn, a_xmx, a_ymn, a_ymx, a_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_bin"}, out_bin, 0);
        chk({tag, "_out_de"}, out_de, 0);
        chk({tag, "_out_hsync"}, out_hsync, 0);
        chk({tag, "_out_vsync"}, out_vsync, 0);
        chk({tag, "_x_min"}, x_min, 0);
        chk({tag, "_x_max"}, x_max, 0);
        chk({tag, "_y_min"}, y_min, 0);
        chk({tag, "_y_max"}, y_max, 0);
        chk({tag, "_x_center"}, x_center, 0);
        chk({tag, "_y_center"}, y_center, 0);
        chk({tag, "_pix_count"}, pix_count, 0);
        chk({tag, "_obj_found"}, obj_found, 0);
        chk({tag, "_frame_valid"}, frame_valid, 0);
    endtask

    function automatic res_t frame_result();
        res_t r;
        r = '0;
        if (a_cnt > 0) begin
            r.xmn = 10'(a_xmn);
            r.xmx = 10'(a_xmx);
            r.ymn = 10'(a_ymn);
            r.ymx = 10'(a_ymx);
            r.xc  = 10'((a_xmn + a_xmx) / 2);
            r.yc  = 10'((a_ymn + a_ymx) / 2);
            r.cnt = (a_cnt > 20'hFFFFF) ? 20'hFFFFF : 20'(a_cnt);
            r.obj = (a_cnt >= 16);
        end
        return r;
    endfunction

    // One clock of stimulus; x/y are the pixel's position within the frame.
    task automatic step(input logic c, input logic de, input logic hs, input logic vs,
                        input logic [7:0] sob, input int x, input int y);
        logic vr;
        ce = c; in_de = de; in_hsync = hs; in_vsync = vs; in_sobel = sob;
        if (c) begin
            last_vid  = {(de && sob >= m_thr) ? 8'hFF : 8'h00, de, hs, vs};
            vr        = vs && !m_prev_vs;
            m_prev_vs = vs;
            if (m_arm_wait == 1) begin
                m_thr = threshold;
                m_arm_wait = 0;
                m_active = 1'b1;
                a_xmn = 1023; a_xmx = 0; a_ymn = 1023; a_ymx = 0; a_cnt = 0;
            end else if (m_arm_wait == 2) begin
                m_arm_wait = 1;
            end else if (m_active) begin
                if (de && sob >= m_thr) begin
                    if (x < a_xmn) a_xmn = x;
                    if (x > a_xmx) a_xmx = x;
                    if (y < a_ymn) a_ymn = y;
                    if (y > a_ymx) a_ymx = y;
                    a_cnt++;
                end
                if (vr) begin
                    res_q.push_back(frame_result());
                    res_due_q.push_back(cyc + 2);
                    m_active = 1'b0;
                    m_arm_wait = 2;
                end
            end else if (vr) begin
                m_arm_wait = 1;
            end
        end
        exp_q.push_back(last_vid);
        exp_due_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int kind, input int x, input int y);
        case (kind)
            K_PASS:  return (x == 10 && y == 5) ? 8'd100 : 8'd99;
            K_RECT:  return (x >= 20 && x <= 40 && y >= 8 && y <= 30) ? 8'd200 : 8'd0;
            K_EMPTY: return 8'd0;
            K_FULL:  return 8'd200;
            default: return ((x == 0 || x == 63) && (y == 0 || y == 63)) ? 8'd200 : 8'd10;
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 0, 0);
    endtask

    task automatic do_vsync();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 0, 0);
        idle(4);
    endtask

    task automatic do_active(input int kind, input int nlines);
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < 64; x++) begin
                if (kind == K_FULL && y == 32 && x == 0) threshold = 8'd250;
                if (kind == K_CORNER && (x % 7) == 3) step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, x, y);
                step(1'b1, 1'b1, 1'b0, 1'b0, pix(kind, x, y), x, y);
            end
            for (int b = 0; b < 8; b++) step(1'b1, 1'b0, (b >= 2 && b < 6), 1'b0, 8'd0, 0, 0);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        ce = 1'b0; in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_sobel = 8'd0;
        m_thr = 8'hFF; m_prev_vs = 1'b0; m_active = 1'b0; m_arm_wait = 0;
        last_vid = '0;
        exp_q.delete(); exp_due_q.delete(); res_q.delete(); res_due_q.delete();
        #1;
        chk_all_zero("rst_now");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pin(input int xmn, input int xmx, input int ymn, input int ymx,
                       input int xc, input int yc, input int cnt, input int obj, input int frames);
        chk("pin_x_min", x_min, xmn);
        chk("pin_x_max", x_max, xmx);
        chk("pin_y_min", y_min, ymn);
        chk("pin_y_max", y_max, ymx);
        chk("pin_x_center", x_center, xc);
        chk("pin_y_center", y_center, yc);
        chk("pin_pix_count", pix_count, cnt);
        chk("pin_obj_found", obj_found, obj);
        chk("pin_model_cnt", cur_res.cnt, cnt);
        chk("pin_model_xc", cur_res.xc, xc);
        chk("pin_model_yc", cur_res.yc, yc);
        chk("pin_frames_published", fv_seen, frames);
    endtask

    // compare process
    always @(negedge clk) begin
        logic fv_exp;
        if (!rst_n) begin
            cur_vid = '0;
            cur_res = '0;
            chk_all_zero("in_reset");
        end else begin
            while (exp_q.size() > 0 && exp_due_q[0] <= cyc) begin
                cur_vid = exp_q.pop_front();
                void'(exp_due_q.pop_front());
            end
            fv_exp = 1'b0;
            if (res_q.size() > 0 && res_due_q[0] <= cyc) begin
                cur_res = res_q.pop_front();
                void'(res_due_q.pop_front());
                fv_exp = 1'b1;
            end
            if (frame_valid) fv_seen++;
            chk("out_bin", out_bin, cur_vid[10:3]);
            chk("out_de", out_de, cur_vid[2]);
            chk("out_hsync", out_hsync, cur_vid[1]);
            chk("out_vsync", out_vsync, cur_vid[0]);
            chk("frame_valid", frame_valid, fv_exp);
            chk("x_min", x_min, cur_res.xmn);
            chk("x_max", x_max, cur_res.xmx);
            chk("y_min", y_min, cur_res.ymn);
            chk("y_max", y_max, cur_res.ymx);
            chk("x_center", x_center, cur_res.xc);
            chk("y_center", y_center, cur_res.yc);
            chk("pix_count", pix_count, cur_res.cnt);
            chk("obj_found", obj_found, cur_res.obj);
        end
    end

    initial begin
        #2;
        reset_dut();
        idle(100);
        chk("idle_no_frame_valid", fv_seen, 0);

        threshold = 8'd100;
        do_vsync();
        do_active(K_PASS, 64);

        threshold = 8'd128;
        do_vsync();
        pin(10, 10, 5, 5, 10, 5, 1, 0, 1);
        do_active(K_RECT, 64);

        do_vsync();
        pin(20, 40, 8, 30, 30, 19, 483, 1, 2);
        do_active(K_EMPTY, 64);

        threshold = 8'd50;
        do_vsync();
        pin(0, 0, 0, 0, 0, 0, 0, 0, 3);
        do_active(K_FULL, 64);

        do_vsync();
        pin(0, 63, 0, 63, 31, 31, 4096, 1, 4);
        do_active(K_FULL, 64);

        threshold = 8'd128;
        do_vsync();
        pin(0, 0, 0, 0, 0, 0, 0, 0, 5);
        do_active(K_CORNER, 64);

        do_vsync();
        pin(0, 63, 0, 63, 31, 31, 4, 0, 6);
        do_active(K_RECT, 30);

        reset_dut();
        idle(5);
        do_vsync();
        chk("no_publish_after_reset_sync", fv_seen, 6);
        chk("results_clear_after_reset", pix_count, 0);
        do_active(K_RECT, 64);

        do_vsync();
        pin(20, 40, 8, 30, 30, 19, 483, 1, 7);
        idle(10);

        $display("final dbg_state=%0d frames=%0d", dbg_state, fv_seen);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
